// File: rtl/midi_pkg.sv
// Shared constants for the MIDI receive path: bit timing, deframer state encoding
// and the MIDI status-byte values that downstream consumers decode.
package midi_pkg;

   localparam int unsigned BOARD_CLK_HZ = 50_000_000;
   localparam int unsigned MIDI_BAUD    = 31250;
   localparam int unsigned CLKS_PER_BIT = BOARD_CLK_HZ / MIDI_BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } rx_state_e;

   localparam logic [7:0] NOTE_ON       = 8'h90;
   localparam logic [7:0] NOTE_OFF      = 8'h80;
   localparam logic [7:0] REALTIME_BASE = 8'hF8;

   function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/midi_bit_timer.sv
// Loadable down-counter that parks at zero; tc flags the zero count so the caller can
// act on it and reload in the same cycle. Shared with the future TX stage.
module midi_bit_timer #(
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 receiver: synchronises the serial line, deframes characters with a
// mid-bit sampling timer and hands bytes to the consumer over valid/ready.
module midi_uart_rx
   import midi_pkg::*;
#(
   parameter int unsigned CLK_HZ = BOARD_CLK_HZ,
   parameter int unsigned BAUD   = MIDI_BAUD
) (
   input  logic       FPGA_CLK1_50,
   input  logic       reset,
   input  logic       midi_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_is_status,
   output logic       framing_err,
   output logic       overrun,
   output logic [7:0] byte_cnt
);

   localparam int unsigned BIT_CLKS  = clks_per_bit(CLK_HZ, BAUD);
   localparam int unsigned HALF_CLKS = BIT_CLKS / 2;
   localparam int unsigned TW        = $clog2(BIT_CLKS);

   logic          rx_meta, rx_s, rx_prev;
   rx_state_e     state_q, state_d;
   logic          timer_load, timer_tc;
   logic [TW-1:0] timer_val;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          shift_en, byte_done, frame_bad, start_edge, accept;

   // Flops reset high so a reset never looks like a start edge.
   always_ff @(posedge FPGA_CLK1_50) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= midi_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign start_edge = rx_prev & ~rx_s;

   midi_bit_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk     (FPGA_CLK1_50),
      .reset   (reset),
      .load    (timer_load),
      .load_val(timer_val),
      .tc      (timer_tc)
   );

   always_ff @(posedge FPGA_CLK1_50) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_edge) state_d = StStart;
         StStart: if (timer_tc) state_d = rx_s ? StIdle : StData;
         StData:  if (timer_tc && bit_idx == 3'd7) state_d = StStop;
         StStop:  if (timer_tc) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      timer_load = 1'b0;
      timer_val  = '0;
      shift_en   = 1'b0;
      byte_done  = 1'b0;
      frame_bad  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_edge) begin
               timer_load = 1'b1;
               timer_val  = TW'(HALF_CLKS - 1);
            end
         end
         StStart: begin
            if (timer_tc && !rx_s) begin
               timer_load = 1'b1;
               timer_val  = TW'(BIT_CLKS - 1);
            end
         end
         StData: begin
            if (timer_tc) begin
               shift_en   = 1'b1;
               timer_load = 1'b1;
               timer_val  = TW'(BIT_CLKS - 1);
            end
         end
         StStop: begin
            if (timer_tc) begin
               byte_done = rx_s;
               frame_bad = ~rx_s;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge FPGA_CLK1_50) begin
      if (reset) begin
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         if (state_q == StStart) begin
            bit_idx <= '0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
         end
         if (shift_en) begin
            shift_reg <= {rx_s, shift_reg[7:1]};
         end
      end
   end

   assign accept = rx_valid & rx_ready;

   // A completing byte may replace the held one only if it is being read this cycle.
   always_ff @(posedge FPGA_CLK1_50) begin
      if (reset) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
         byte_cnt    <= '0;
      end else begin
         framing_err <= frame_bad;
         overrun     <= 1'b0;
         if (byte_done) begin
            if (!rx_valid || accept) begin
               rx_data  <= shift_reg;
               rx_valid <= 1'b1;
               byte_cnt <= byte_cnt + 8'd1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign rx_is_status = rx_valid & rx_data[7];

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench: a full-rate instance pins the absolute frame latency, a scaled
// instance (16 clocks/bit) runs every scenario against a transaction-level model.
module tb_midi_uart_rx;

   localparam int CPB = 16;
   localparam int HB  = CPB / 2;
   localparam int LAT = 3 + HB + 9 * CPB;  // drive edge to visible completion

   typedef struct {
      int         due;
      logic [7:0] data;
      bit         ferr;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_line = 1'b1;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data, byte_cnt;
   logic       rx_valid, rx_is_status, framing_err, overrun;

   logic       big_line = 1'b1;
   logic [7:0] big_data, big_cnt;
   logic       big_valid, big_status, big_ferr, big_ovr;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   ev_t        evq[$];
   bit         m_init = 1'b0;
   logic       m_valid, m_ferr, m_ovr;
   logic [7:0] m_data, m_cnt;

   int ferr_seen, ovr_seen, taken;

   always #10 clk = ~clk;

   midi_uart_rx #(
      .CLK_HZ(500000),
      .BAUD  (31250)
   ) dut (
      .FPGA_CLK1_50(clk),
      .reset       (reset),
      .midi_rx     (rx_line),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_is_status(rx_is_status),
      .framing_err (framing_err),
      .overrun     (overrun),
      .byte_cnt    (byte_cnt)
   );

   midi_uart_rx big (
      .FPGA_CLK1_50(clk),
      .reset       (reset),
      .midi_rx     (big_line),
      .rx_data     (big_data),
      .rx_valid    (big_valid),
      .rx_ready    (1'b1),
      .rx_is_status(big_status),
      .framing_err (big_ferr),
      .overrun     (big_ovr),
      .byte_cnt    (big_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sends one 8N1 character on the scaled line and tells the model what must follow.
   task automatic send_byte(input logic [7:0] b, input bit stop);
      ev_t e;
      e.due  = cyc + LAT;
      e.data = b;
      e.ferr = !stop;
      evq.push_back(e);
      rx_line = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         tick(CPB);
      end
      rx_line = stop;
      tick(CPB);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      ferr_seen = 0;
      ovr_seen  = 0;
      taken     = 0;
      tick(CPB);
   endtask

   // Model: frame completions arrive at their scheduled cycle, then the holding-register rules.
   initial forever begin
      bit   accept, good;
      ev_t  ev;
      @(posedge clk);
      cyc = cyc + 1;
      if (reset) begin
         m_init  = 1'b1;
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_cnt   = 8'h00;
         m_ferr  = 1'b0;
         m_ovr   = 1'b0;
         evq.delete();
      end else begin
         accept = m_valid && rx_ready;
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
         good   = 1'b0;
         if (evq.size() > 0 && evq[0].due == cyc) begin
            ev = evq.pop_front();
            if (ev.ferr) m_ferr = 1'b1;
            else good = 1'b1;
         end
         if (good) begin
            if (!m_valid || accept) begin
               m_data  = ev.data;
               m_valid = 1'b1;
               m_cnt   = m_cnt + 8'd1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (accept) begin
            m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model, plus pulse counters for the literal checks.
   initial forever begin
      @(negedge clk);
      if (m_init) begin
         check("rx_valid", rx_valid, m_valid);
         check("rx_data", rx_data, m_data);
         check("byte_cnt", byte_cnt, m_cnt);
         check("framing_err", framing_err, m_ferr);
         check("overrun", overrun, m_ovr);
         if (m_valid) check("rx_is_status", rx_is_status, m_data[7]);
         ferr_seen += int'(framing_err);
         ovr_seen  += int'(overrun);
         taken     += int'(rx_valid && rx_ready);
      end
   end

   initial begin
      int         big_start, big_lat;
      bit         big_seen;
      logic [7:0] big_byte;
      logic       big_stat_s, big_err_s, big_after;
      logic [7:0] big_cnt_s;
      logic [9:0] frame;

      tick(3);
      reset = 1'b0;
      tick(4);

      // Full-rate 0x90: absolute latency and output values.
      frame     = {1'b1, 8'h90, 1'b0};
      big_start = cyc;
      big_seen  = 1'b0;
      big_lat   = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               big_line = frame[i];
               tick(1600);
            end
         end
         begin
            for (int i = 0; i < 20000 && !big_seen; i++) begin
               @(negedge clk);
               if (big_valid) begin
                  big_seen   = 1'b1;
                  big_lat    = cyc - big_start;
                  big_byte   = big_data;
                  big_stat_s = big_status;
                  big_cnt_s  = big_cnt;
                  big_err_s  = big_ferr | big_ovr;
                  @(negedge clk);
                  big_after  = big_valid;
               end
            end
         end
      join
      check("big_seen", big_seen, 1);
      if (big_seen) begin
         check("big_latency", big_lat, 15203);
         check("big_data", big_byte, 8'h90);
         check("big_status", big_stat_s, 1);
         check("big_cnt", big_cnt_s, 1);
         check("big_errs", big_err_s, 0);
         check("big_pulse", big_after, 0);
      end

      // 1: single status byte.
      do_reset();
      send_byte(8'h90, 1'b1);
      tick(CPB);
      check("t1_data", rx_data, 8'h90);
      check("t1_cnt", byte_cnt, 1);
      check("t1_taken", taken, 1);

      // 2: back-to-back frames.
      do_reset();
      send_byte(8'h90, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h7F, 1'b1);
      tick(CPB);
      check("t2_data", rx_data, 8'h7F);
      check("t2_cnt", byte_cnt, 3);
      check("t2_taken", taken, 3);
      check("t2_errs", ferr_seen + ovr_seen, 0);

      // 3: overrun while the consumer stalls.
      do_reset();
      rx_ready = 1'b0;
      send_byte(8'h3C, 1'b1);
      send_byte(8'h40, 1'b1);
      tick(CPB);
      check("t3_data", rx_data, 8'h3C);
      check("t3_valid", rx_valid, 1);
      check("t3_cnt", byte_cnt, 1);
      check("t3_ovr", ovr_seen, 1);
      rx_ready = 1'b1;
      tick(1);
      check("t3_drop", rx_valid, 0);

      // 4: framing error, held break, then recovery.
      do_reset();
      send_byte(8'h55, 1'b0);
      tick(5 * CPB);
      rx_line = 1'b1;
      tick(CPB);
      check("t4_ferr", ferr_seen, 1);
      check("t4_cnt_err", byte_cnt, 0);
      send_byte(8'hAA, 1'b1);
      tick(CPB);
      check("t4_data", rx_data, 8'hAA);
      check("t4_cnt", byte_cnt, 1);

      // 5: short glitch on the idle line.
      do_reset();
      rx_line = 1'b0;
      tick(CPB / 4);
      rx_line = 1'b1;
      tick(2 * CPB);
      check("t5_quiet", taken + ferr_seen, 0);
      send_byte(8'hF8, 1'b1);
      tick(CPB);
      check("t5_data", rx_data, 8'hF8);
      check("t5_cnt", byte_cnt, 1);

      // 6: reset during the 4th data bit aborts the frame.
      do_reset();
      fork
         send_byte(8'hFF, 1'b1);
         begin
            tick(4 * CPB + CPB / 2);
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
         end
      join
      tick(CPB);
      check("t6_none", taken, 0);
      check("t6_cnt_rst", byte_cnt, 0);
      send_byte(8'h12, 1'b1);
      tick(CPB);
      check("t6_data", rx_data, 8'h12);
      check("t6_cnt", byte_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
